// File: rtl/gps_nmea_formatter.sv
// Serialises latched GPS time/position fields as an ASCII $GPGGA sentence,
// one byte per valid/ready transfer, with optional checksum and CR/LF.
module gps_nmea_formatter #(
    parameter bit CHECKSUM_EN = 1'b1,
    parameter bit EMIT_CRLF   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  utc_hh,
    input  logic [5:0]  utc_mm,
    input  logic [5:0]  utc_ss,
    input  logic [15:0] latitude_deg,
    input  logic [15:0] latitude_min,
    input  logic        lat_south,
    input  logic [23:0] longitude_deg,
    input  logic [15:0] longitude_min,
    input  logic        lon_west,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    localparam int LEN = 28 + 3 * int'(CHECKSUM_EN) + 2 * int'(EMIT_CRLF);
    localparam logic [5:0] LAST = 6'(LEN - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] SEND = 2'd2;

    logic [1:0]  state;
    logic [5:0]  idx;
    logic [7:0]  csum;

    logic [4:0]  hh_q;
    logic [5:0]  mm_q;
    logic [5:0]  ss_q;
    logic [15:0] lat_deg_q;
    logic [15:0] lat_min_q;
    logic [23:0] lon_deg_q;
    logic [15:0] lon_min_q;
    logic        south_q;
    logic        west_q;

    logic [23:0] time_bcd;
    logic [15:0] lat_bcd;
    logic [19:0] lon_bcd;

    logic [5:0]  sel;
    logic [7:0]  nbyte;
    logic        xfer;

    function automatic logic [6:0] sat99(input logic [15:0] v);
        return (v > 16'd99) ? 7'd99 : v[6:0];
    endfunction

    function automatic logic [7:0] bcd2(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    function automatic logic [11:0] bcd3(input logic [23:0] v);
        logic [9:0] s;
        s = (v > 24'd999) ? 10'd999 : v[9:0];
        return {4'(s / 10'd100), 4'((s / 10'd10) % 10'd10), 4'(s % 10'd10)};
    endfunction

    function automatic logic [7:0] asc(input logic [3:0] d);
        return {4'h3, d};
    endfunction

    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : 8'h37 + {4'h0, n};
    endfunction

    assign xfer = tx_valid & tx_ready;

    // Byte that follows the one currently presented.
    always_comb begin
        sel   = idx + 6'd1;
        nbyte = 8'h00;
        case (sel)
            6'd0:  nbyte = "$";
            6'd1:  nbyte = "G";
            6'd2:  nbyte = "P";
            6'd3:  nbyte = "G";
            6'd4:  nbyte = "G";
            6'd5:  nbyte = "A";
            6'd6:  nbyte = ",";
            6'd7:  nbyte = asc(time_bcd[23:20]);
            6'd8:  nbyte = asc(time_bcd[19:16]);
            6'd9:  nbyte = asc(time_bcd[15:12]);
            6'd10: nbyte = asc(time_bcd[11:8]);
            6'd11: nbyte = asc(time_bcd[7:4]);
            6'd12: nbyte = asc(time_bcd[3:0]);
            6'd13: nbyte = ",";
            6'd14: nbyte = asc(lat_bcd[15:12]);
            6'd15: nbyte = asc(lat_bcd[11:8]);
            6'd16: nbyte = asc(lat_bcd[7:4]);
            6'd17: nbyte = asc(lat_bcd[3:0]);
            6'd18: nbyte = ",";
            6'd19: nbyte = south_q ? "S" : "N";
            6'd20: nbyte = ",";
            6'd21: nbyte = asc(lon_bcd[19:16]);
            6'd22: nbyte = asc(lon_bcd[15:12]);
            6'd23: nbyte = asc(lon_bcd[11:8]);
            6'd24: nbyte = asc(lon_bcd[7:4]);
            6'd25: nbyte = asc(lon_bcd[3:0]);
            6'd26: nbyte = ",";
            6'd27: nbyte = west_q ? "W" : "E";
            default: begin
                if (CHECKSUM_EN) begin
                    case (sel)
                        6'd28:   nbyte = "*";
                        6'd29:   nbyte = hex(csum[7:4]);
                        6'd30:   nbyte = hex(csum[3:0]);
                        6'd31:   nbyte = 8'h0D;
                        6'd32:   nbyte = 8'h0A;
                        default: nbyte = 8'h00;
                    endcase
                end else begin
                    case (sel)
                        6'd28:   nbyte = 8'h0D;
                        6'd29:   nbyte = 8'h0A;
                        default: nbyte = 8'h00;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 6'd0;
            csum      <= 8'h00;
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hh_q      <= '0;
            mm_q      <= '0;
            ss_q      <= '0;
            lat_deg_q <= '0;
            lat_min_q <= '0;
            lon_deg_q <= '0;
            lon_min_q <= '0;
            south_q   <= 1'b0;
            west_q    <= 1'b0;
            time_bcd  <= '0;
            lat_bcd   <= '0;
            lon_bcd   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        hh_q      <= utc_hh;
                        mm_q      <= utc_mm;
                        ss_q      <= utc_ss;
                        lat_deg_q <= latitude_deg;
                        lat_min_q <= latitude_min;
                        lon_deg_q <= longitude_deg;
                        lon_min_q <= longitude_min;
                        south_q   <= lat_south;
                        west_q    <= lon_west;
                        idx       <= 6'd0;
                        csum      <= 8'h00;
                        busy      <= 1'b1;
                        state     <= CONV;
                    end
                end
                CONV: begin
                    time_bcd <= {bcd2({2'b00, hh_q}),
                                 bcd2({1'b0, mm_q}),
                                 bcd2({1'b0, ss_q})};
                    lat_bcd  <= {bcd2(sat99(lat_deg_q)),
                                 bcd2(sat99(lat_min_q))};
                    lon_bcd  <= {bcd3(lon_deg_q),
                                 bcd2(sat99(lon_min_q))};
                    tx_data  <= "$";
                    tx_valid <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    if (xfer) begin
                        // Checksum covers the bytes between '$' and '*'.
                        if (idx != 6'd0 && idx < 6'd28) begin
                            csum <= csum ^ tx_data;
                        end
                        if (idx == LAST) begin
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            idx     <= sel;
                            tx_data <= nbyte;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
